uart_rx_param: RTL and testbench

Parametrised second-generation UART receiver. It converts an asynchronous serial line into parallel words with configurable word length, baud divisor and stop-bit count. It adds false-start rejection, framing-error and overrun reporting, and optional parity checking. It sits behind the RX pin and in front of the command/packet logic, and it interoperates with the existing 8N1 transmitter when DATA_BITS=8, STOP_BITS=1 and parity is compiled out.

---
 rtl/uart_rx_param.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver. It rejects false starts and reports framing errors,
//   overrun and (optionally) parity errors.
// Latency: rx_data/rdy/flags update 1 clk after the last stop-bit sample. RX reaches the FSM
//   after a 2-flop synchronizer.
// Backpressure: none. A word that completes while rdy=1 overwrites rx_data and sets overrun.
// Ports: clk, rst_n (async, active-low), RX (async serial in, idles high), clr_rdy (1-cycle ack);
//   rx_data, rdy, frm_err, par_err, overrun (registered; error flags are sticky until clr_rdy).
// Build option: define UART_PARITY_EN to expect a parity bit after the data. The parity is
//   even, or odd when ODD_PARITY=1. Without the macro, par_err is tied to 0.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int BAUD_DIV   = 2604,
  parameter int STOP_BITS  = 1,
  parameter int ODD_PARITY = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX,
  input  logic                 clr_rdy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rdy,
  output logic                 frm_err,
  output logic                 par_err,
  output logic                 overrun
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] C_HALF  = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] C_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] C_DLAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] C_SLAST = BW'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || BAUD_DIV < 8 || STOP_BITS < 1 || STOP_BITS > 2 ||
      ODD_PARITY < 0 || ODD_PARITY > 1) begin : g_param_err
    $error("uart_rx_param: illegal parameter value");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [CW-1:0]          r_cnt, w_cnt_nxt;
  logic [BW-1:0]          r_bit, w_bit_nxt;
  logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
  logic                   r_stop_bad, w_stop_bad_nxt;
  logic                   w_done;
`ifdef UART_PARITY_EN
  logic                   r_par_bad, w_par_bad_nxt;
`endif

  // Synchronizer idles high so that releasing reset never looks like a start edge.
  logic r_rx_meta, r_rx_s, r_rx_prev;
  logic w_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= RX;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  assign w_fall = r_rx_prev & ~r_rx_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // The counter is loaded with 1 on the start edge, so START ends exactly BAUD_DIV/2 cycles
  // after t0. Each later sample wraps it to 0 and waits a full BAUD_DIV.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt + 1'b1;
    w_bit_nxt      = r_bit;
    w_shift_nxt    = r_shift;
    w_stop_bad_nxt = r_stop_bad;
    w_done         = 1'b0;
`ifdef UART_PARITY_EN
    w_par_bad_nxt  = r_par_bad;
`endif
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt      = '0;
        w_bit_nxt      = '0;
        w_stop_bad_nxt = 1'b0;
`ifdef UART_PARITY_EN
        w_par_bad_nxt  = 1'b0;
`endif
        if (w_fall) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = CW'(1);
        end
      end
      S_START: begin
        if (r_cnt == C_HALF) begin
          w_cnt_nxt   = '0;
          w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == C_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_rx_s, r_shift[DATA_BITS-1:1]};
          if (r_bit == C_DLAST) begin
            w_bit_nxt   = '0;
`ifdef UART_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (r_cnt == C_LAST) begin
          w_cnt_nxt     = '0;
          w_par_bad_nxt = r_rx_s ^ (^r_shift) ^ (ODD_PARITY != 0);
          w_state_nxt   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (r_cnt == C_LAST) begin
          w_cnt_nxt      = '0;
          w_stop_bad_nxt = r_stop_bad | ~r_rx_s;
          if (r_bit == C_SLAST) begin
            // Back to IDLE right away so a start edge is accepted in the rest of the stop bit.
            w_bit_nxt   = '0;
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_stop_bad <= 1'b0;
`ifdef UART_PARITY_EN
      r_par_bad  <= 1'b0;
`endif
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_bit      <= w_bit_nxt;
      r_shift    <= w_shift_nxt;
      r_stop_bad <= w_stop_bad_nxt;
`ifdef UART_PARITY_EN
      r_par_bad  <= w_par_bad_nxt;
`endif
    end
  end

  // A completion wins over a clr_rdy in the same cycle. The flags then describe only the new
  // frame, and overrun stays clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data <= '0;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      overrun <= 1'b0;
    end else if (w_done) begin
      rx_data <= r_shift;
      rdy     <= 1'b1;
      frm_err <= (frm_err & ~clr_rdy) | w_stop_bad_nxt;
      overrun <= (overrun | rdy) & ~clr_rdy;
    end else if (clr_rdy) begin
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      overrun <= 1'b0;
    end
  end

`ifdef UART_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       par_err <= 1'b0;
    else if (w_done)  par_err <= (par_err & ~clr_rdy) | r_par_bad;
    else if (clr_rdy) par_err <= 1'b0;
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int BD_A = 16;
  localparam int DB_A = 8;
  localparam int SB_A = 1;
  localparam int BD_B = 10;
  localparam int DB_B = 7;
  localparam int SB_B = 2;
  localparam int ODD  = 0;
`ifdef UART_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1, clr_a = 1'b0, clr_b = 1'b0;
  logic [DB_A-1:0] data_a;
  logic [DB_B-1:0] data_b;
  logic rdy_a, frm_a, par_a, ovr_a;
  logic rdy_b, frm_b, par_b, ovr_b;

  always #5 clk = ~clk;

  uart_rx_param #(.DATA_BITS(DB_A), .BAUD_DIV(BD_A), .STOP_BITS(SB_A), .ODD_PARITY(ODD)) u_a (
    .clk(clk), .rst_n(rst_n), .RX(rx_a), .clr_rdy(clr_a), .rx_data(data_a),
    .rdy(rdy_a), .frm_err(frm_a), .par_err(par_a), .overrun(ovr_a));

  uart_rx_param #(.DATA_BITS(DB_B), .BAUD_DIV(BD_B), .STOP_BITS(SB_B), .ODD_PARITY(ODD)) u_b (
    .clk(clk), .rst_n(rst_n), .RX(rx_b), .clr_rdy(clr_b), .rx_data(data_b),
    .rdy(rdy_b), .frm_err(frm_b), .par_err(par_b), .overrun(ovr_b));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: what the host should see for each receiver.
  bit          m_rdy[2], m_frm[2], m_par[2], m_ovr[2];
  logic [31:0] m_data[2];

  function automatic int bd_of(int s); return (s != 0) ? BD_B : BD_A; endfunction
  function automatic int db_of(int s); return (s != 0) ? DB_B : DB_A; endfunction
  function automatic int sb_of(int s); return (s != 0) ? SB_B : SB_A; endfunction
  function automatic logic [31:0] cur_rdy(int s);  return (s != 0) ? 32'(rdy_b)  : 32'(rdy_a);  endfunction
  function automatic logic [31:0] cur_data(int s); return (s != 0) ? 32'(data_b) : 32'(data_a); endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(int s, string tag);
    chk($sformatf("%s[%0d] rdy", tag, s), cur_rdy(s), 32'(m_rdy[s]));
    chk($sformatf("%s[%0d] rx_data", tag, s), cur_data(s), m_data[s]);
    chk($sformatf("%s[%0d] frm_err", tag, s), (s != 0) ? 32'(frm_b) : 32'(frm_a), 32'(m_frm[s]));
    chk($sformatf("%s[%0d] par_err", tag, s), (s != 0) ? 32'(par_b) : 32'(par_a), 32'(m_par[s]));
    chk($sformatf("%s[%0d] overrun", tag, s), (s != 0) ? 32'(ovr_b) : 32'(ovr_a), 32'(m_ovr[s]));
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_rdy[s] = 0; m_frm[s] = 0; m_par[s] = 0; m_ovr[s] = 0; m_data[s] = '0;
    end
  endtask

  task automatic model_done(int s, logic [31:0] d, bit fb, bit pb, bit clr_same);
    if (clr_same) begin
      m_ovr[s] = 0; m_frm[s] = fb; m_par[s] = pb;
    end else begin
      m_ovr[s] = m_ovr[s] | m_rdy[s]; m_frm[s] = m_frm[s] | fb; m_par[s] = m_par[s] | pb;
    end
    m_rdy[s]  = 1;
    m_data[s] = d;
  endtask

  task automatic pulse_clr(int s);
    @(negedge clk);
    if (s != 0) clr_b = 1'b1; else clr_a = 1'b1;
    @(negedge clk);
    clr_b = 1'b0; clr_a = 1'b0;
    m_rdy[s] = 0; m_frm[s] = 0; m_par[s] = 0; m_ovr[s] = 0;
  endtask

  // Drives one frame, one level per bit period, changing RX on falling clock edges.
  // RX falls at a negedge; rx_s reaches 0 two rising edges later (t0), and the result is
  // visible after rising edge 2 + BD/2 + (DB+P+SB)*BD + 1, counted from the falling edge.
  // 'live' = 0 marks a frame that is expected to be destroyed (no checks, no model update).
  task automatic send_frame(int s, logic [31:0] d, bit par_flip, bit [1:0] stop_lo,
                            bit clr_done, bit live);
    int bd, db, sb, lat, n;
    bit lv[$];
    bit par, fb;
    logic [31:0] r0, mask;
    bd = bd_of(s); db = db_of(s); sb = sb_of(s);
    lat  = 2 + bd / 2 + (db + P + sb) * bd + 1;
    mask = (32'd1 << db) - 32'd1;
    par  = (ODD != 0);
    fb   = 0;
    r0   = '0;
    lv.push_back(1'b0);
    for (int i = 0; i < db; i++) begin
      lv.push_back(d[i]);
      par = par ^ d[i];
    end
    if (P == 1) lv.push_back(par ^ par_flip);
    for (int k = 0; k < sb; k++) begin
      lv.push_back(!stop_lo[k]);
      fb = fb | stop_lo[k];
    end
    n = lv.size() * bd;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      if (s != 0) rx_b = lv[j / bd]; else rx_a = lv[j / bd];
      if (clr_done) begin
        if (s != 0) clr_b = (j == lat - 1); else clr_a = (j == lat - 1);
      end
      if (j == 0) r0 = cur_rdy(s);
      if (live && r0 == 32'd0 && j == lat - 1)
        chk($sformatf("latency[%0d] rdy before completion", s), cur_rdy(s), 32'd0);
      if (live && r0 == 32'd0 && j == lat) begin
        chk($sformatf("latency[%0d] rdy at completion", s), cur_rdy(s), 32'd1);
        chk($sformatf("latency[%0d] rx_data at completion", s), cur_data(s), d & mask);
      end
    end
    @(negedge clk);
    if (s != 0) begin rx_b = 1'b1; clr_b = 1'b0; end
    else begin rx_a = 1'b1; clr_a = 1'b0; end
    if (live) model_done(s, d & mask, fb, (P == 1) && par_flip, clr_done);
  endtask

  initial begin
    int          rs;
    logic [31:0] rd;
    bit          rpf, rcd;
    bit [1:0]    rsl;

    model_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all(0, "reset");
    check_all(1, "reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic 8N1 frame with exact completion timing, then acknowledge.
    send_frame(0, 32'hA5, 0, 2'b00, 0, 1);
    check_all(0, "basic");
    pulse_clr(0);
    check_all(0, "basic clr");

    // False start: short low pulse must be ignored; the next frame must be received.
    @(negedge clk); rx_a = 1'b0;
    repeat (4) @(negedge clk); rx_a = 1'b1;
    repeat (2 * BD_A) @(negedge clk);
    check_all(0, "false start");
    send_frame(0, 32'h3C, 0, 2'b00, 0, 1);
    check_all(0, "after false start");
    pulse_clr(0);

    // Framing error, then overrun without acknowledge, then clear.
    send_frame(0, 32'hFF, 0, 2'b01, 0, 1);
    check_all(0, "framing");
    send_frame(0, 32'h00, 0, 2'b00, 0, 1);
    check_all(0, "overrun");
    pulse_clr(0);
    check_all(0, "flags clr");

`ifdef UART_PARITY_EN
    send_frame(0, 32'h07, 0, 2'b00, 0, 1);
    check_all(0, "parity good");
    pulse_clr(0);
    send_frame(0, 32'h07, 1, 2'b00, 0, 1);
    check_all(0, "parity bad");
    pulse_clr(0);
`endif

    // Reset during data bit 3 while a previous word is still pending.
    send_frame(0, 32'h81, 0, 2'b00, 0, 1);
    check_all(0, "pre reset");
    fork
      send_frame(0, 32'hC3, 0, 2'b00, 0, 0);
      begin
        repeat (4 * BD_A + BD_A / 2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all(0, "reset mid frame");
        check_all(1, "reset mid frame");
      end
    join
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(0, 32'h5A, 0, 2'b00, 0, 1);
    check_all(0, "after reset");

    // 7-bit words, 2 stop bits: normal word, then low second stop bit with clr at completion.
    send_frame(1, 32'h55, 0, 2'b00, 0, 1);
    check_all(1, "width");
    send_frame(1, 32'h2A, 0, 2'b10, 1, 1);
    check_all(1, "stop2 clr same cycle");
    pulse_clr(1);
    check_all(1, "width clr");

    // Randomized frames on both receivers.
    for (int it = 0; it < 40; it++) begin
      rs     = $urandom_range(0, 1);
      rd     = $urandom;
      rpf    = ($urandom_range(0, 3) == 0);
      rsl[0] = ($urandom_range(0, 5) == 0);
      rsl[1] = ($urandom_range(0, 5) == 0);
      rcd    = ($urandom_range(0, 4) == 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_frame(rs, rd, rpf, rsl, rcd, 1);
      check_all(rs, "random");
      if ($urandom_range(0, 1) == 1) begin
        pulse_clr(rs);
        check_all(rs, "random clr");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
